// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and helpers
package uart_pkg;

    typedef enum logic [1:0] {
        HALF_PERIOD,
        ONE_PERIOD,
        ONE_AND_HALF_PERIODS,
        TWO_PERIODS
    } stop_bit_mode_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_FINISH
    } rx_state_t;

    function automatic logic [7:0] bit_reverse(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = d[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - N-flop metastability synchronizer with configurable reset value
module uart_sync #(
    parameter int   N         = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_nrst,
    input  logic i_d,
    output logic o_q
);

    logic [N-1:0] sync_q;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            sync_q <= {N{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[N-2:0], i_d};
        end
    end

    assign o_q = sync_q[N-1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver feeding the RX FIFO
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic           i_clk,
    input  logic           i_nrst,
    input  logic           i_rx,
    output logic           o_valid,
    output logic [7:0]     o_data,
    output logic           o_parity_err,
    output logic           o_frame_err,
    output logic           o_break,
    output logic           o_overrun_err,
    output logic           o_rx_status,
    output logic           o_rx_started,
    output logic           o_rts,
    input  logic           i_fifo_full,
    input  logic           i_hw_flow_control_enable,
    input  logic           i_parity_enable,
    input  stop_bit_mode_t i_stop_bit_mode,
    input  logic [31:0]    i_bit_length,
    input  logic           i_msb_first
);

    rx_state_t          state, state_nxt;
    logic               rx_s, rx_d, armed;
    logic [SYNC_STAGES:0] warm;
    logic [31:0]        bit_cnt, len_buf;
    logic               par_en_buf, msb_buf;
    stop_bit_mode_t     stop_mode_buf;
    logic [2:0]         bit_idx;
    logic [7:0]         shift_q, data_hold, rx_byte;
    logic               par_bit, stop_bit;
    logic               period_done, mid_sample, stop_sample;
    logic               fall, accept, skip_start;

    uart_sync #(.N(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync (
        .i_clk  (i_clk),
        .i_nrst (i_nrst),
        .i_d    (i_rx),
        .o_q    (rx_s)
    );

    assign period_done = (bit_cnt >= len_buf);
    assign mid_sample  = (bit_cnt == {1'b0, len_buf[31:1]});
    assign stop_sample = (stop_mode_buf == HALF_PERIOD) ? mid_sample : period_done;
    assign fall        = armed & rx_d & ~rx_s;
    assign accept      = fall & ((state == RX_IDLE) || (state == RX_FINISH));
    // With a 1-clk bit the edge cycle is already the start-bit centre.
    assign skip_start  = accept & (i_bit_length == 32'd0);
    assign rx_byte     = msb_buf ? bit_reverse(shift_q) : shift_q;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state <= RX_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RX_IDLE, RX_FINISH: begin
                if (accept) begin
                    state_nxt = skip_start ? RX_DATA : RX_START;
                end else if (state == RX_FINISH) begin
                    state_nxt = RX_IDLE;
                end
            end
            RX_START:  if (mid_sample) state_nxt = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:   if (period_done && bit_idx == 3'd7) state_nxt = par_en_buf ? RX_PARITY : RX_STOP;
            RX_PARITY: if (period_done) state_nxt = RX_STOP;
            RX_STOP:   if (stop_sample) state_nxt = RX_FINISH;
            default:   state_nxt = RX_IDLE;
        endcase
    end

    always_comb begin
        o_valid       = (state == RX_FINISH) & ~i_fifo_full;
        o_overrun_err = (state == RX_FINISH) & i_fifo_full;
        o_data        = o_valid ? rx_byte : data_hold;
        o_parity_err  = o_valid & par_en_buf & (par_bit != ^rx_byte);
        o_frame_err   = o_valid & ~stop_bit;
        o_break       = o_valid & (rx_byte == 8'h00) & (~par_en_buf | ~par_bit) & ~stop_bit;
        o_rx_status   = (state != RX_IDLE);
        o_rx_started  = ((state == RX_START) & mid_sample & ~rx_s) | skip_start;
        o_rts         = i_hw_flow_control_enable ? ~i_fifo_full : 1'b1;
    end

    // A line held low through reset release must go high before it can start a frame.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            rx_d  <= 1'b1;
            warm  <= '0;
            armed <= 1'b0;
        end else begin
            rx_d  <= rx_s;
            warm  <= {warm[SYNC_STAGES-1:0], 1'b1};
            armed <= armed | (warm[SYNC_STAGES] & rx_s);
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            bit_cnt       <= '0;
            len_buf       <= '0;
            par_en_buf    <= 1'b0;
            msb_buf       <= 1'b0;
            stop_mode_buf <= ONE_PERIOD;
            bit_idx       <= '0;
            shift_q       <= '0;
            par_bit       <= 1'b0;
            stop_bit      <= 1'b1;
            data_hold     <= '0;
        end else begin
            if (accept) begin
                len_buf       <= i_bit_length;
                par_en_buf    <= i_parity_enable;
                msb_buf       <= i_msb_first;
                stop_mode_buf <= i_stop_bit_mode;
                bit_idx       <= '0;
                par_bit       <= 1'b0;
            end
            if (state == RX_IDLE || accept || (state == RX_START && mid_sample) || period_done) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + 32'd1;
            end
            if (state == RX_DATA && period_done) begin
                shift_q <= {rx_s, shift_q[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
            if (state == RX_PARITY && period_done) begin
                par_bit <= rx_s;
            end
            if (state == RX_STOP && stop_sample) begin
                stop_bit <= rx_s;
            end
            if (state == RX_FINISH && !i_fifo_full) begin
                data_hold <= rx_byte;
            end
        end
    end

endmodule
